// File: rtl/data_array_rmw_ctrl_pkg.sv
// ============================================================================
// Module   : data_array_pkg
// Brief    : Shared types and address-field constants for the data array
//            access controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_array_pkg;

  localparam int ARR_ADDR_W  = 11;
  localparam int LANE_W      = 32;
  localparam int BYTE_ADDR_W = ARR_ADDR_W + 3;

  // Byte address layout: [BYTE_ADDR_W-1:ROW_LSB] row, [LANE_BIT] lane, [1:0] byte
  localparam int ROW_LSB  = 3;
  localparam int ROW_MSB  = BYTE_ADDR_W - 1;
  localparam int LANE_BIT = 2;

  localparam logic [3:0] MASK_FULL = 4'hF;
  localparam logic [3:0] MASK_NONE = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RESP = 2'd2
  } ctrl_state_e;

  function automatic logic [1:0] lane_onehot(input logic lane);
    return lane ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_array_rmw_ctrl_if.sv
// ============================================================================
// Module   : data_array_rmw_ctrl_if
// Brief    : Core request/response port plus array RW port of the controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_array_rmw_ctrl_if #(
  parameter int ARR_ADDR_W = data_array_pkg::ARR_ADDR_W,
  parameter int LANE_W     = data_array_pkg::LANE_W
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ARR_ADDR_W+2:0]   req_addr;
  logic [LANE_W-1:0]       req_data;
  logic [LANE_W/8-1:0]     req_mask;

  logic                    resp_valid;
  logic                    resp_ready;
  logic                    resp_write;
  logic [LANE_W-1:0]       resp_data;

  logic                    arr_en;
  logic                    arr_wmode;
  logic [ARR_ADDR_W-1:0]   arr_addr;
  logic [2*LANE_W-1:0]     arr_wdata;
  logic [1:0]              arr_wmask;
  logic [2*LANE_W-1:0]     arr_rdata;

  // Controller side
  modport slave (
    input  req_valid, req_write, req_addr, req_data, req_mask,
    output req_ready,
    output resp_valid, resp_write, resp_data,
    input  resp_ready,
    output arr_en, arr_wmode, arr_addr, arr_wdata, arr_wmask,
    input  arr_rdata
  );

  // Core plus array side
  modport master (
    output req_valid, req_write, req_addr, req_data, req_mask,
    input  req_ready,
    input  resp_valid, resp_write, resp_data,
    output resp_ready,
    input  arr_en, arr_wmode, arr_addr, arr_wdata, arr_wmask,
    output arr_rdata
  );

endinterface

`default_nettype wire

// File: rtl/data_array_rmw_ctrl_byte_merge.sv
// ============================================================================
// Module   : byte_merge
// Brief    : Combinational 32-bit byte merge of new over old data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_merge (
  input  logic [31:0] i_new_data,
  input  logic [31:0] i_old_data,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_merged
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign o_merged[gi*8 +: 8] = i_mask[gi] ? i_new_data[gi*8 +: 8]
                                              : i_old_data[gi*8 +: 8];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/data_array_rmw_ctrl.sv
// ============================================================================
// Module   : data_array_rmw_ctrl
// Brief    : Word access controller for the 2-lane data array; partial-byte
//            writes are done as read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_array_rmw_ctrl
  import data_array_pkg::*;
#(
  parameter int ARR_ADDR_W = data_array_pkg::ARR_ADDR_W,
  parameter int LANE_W     = data_array_pkg::LANE_W
) (
  input  logic                  clock,
  input  logic                  reset,
  data_array_rmw_ctrl_if.slave  bus
);

  ctrl_state_e              r_state;
  ctrl_state_e              w_state_next;

  logic                     r_lane;
  logic                     r_write;
  logic [3:0]               r_mask;
  logic [LANE_W-1:0]        r_data;
  logic [ARR_ADDR_W-1:0]    r_row;

  logic                     r_resp_write;
  logic [LANE_W-1:0]        r_resp_data;

  logic                     w_req_ready;
  logic                     w_accept;
  logic [ARR_ADDR_W-1:0]    w_req_row;
  logic                     w_req_lane;
  logic                     w_mask_full;
  logic                     w_mask_none;
  logic [LANE_W-1:0]        w_old_lane;
  logic [LANE_W-1:0]        w_merged;

  logic                     w_arr_en;
  logic                     w_arr_wmode;
  logic [ARR_ADDR_W-1:0]    w_arr_addr;
  logic [2*LANE_W-1:0]      w_arr_wdata;
  logic [1:0]               w_arr_wmask;

  logic                     w_unused_addr;

  assign w_req_row   = bus.req_addr[ARR_ADDR_W+2:ROW_LSB];
  assign w_req_lane  = bus.req_addr[LANE_BIT];
  assign w_mask_full = (bus.req_mask == MASK_FULL);
  assign w_mask_none = (bus.req_mask == MASK_NONE);
  assign w_unused_addr = ^bus.req_addr[1:0];

  assign w_req_ready = (r_state == ST_IDLE) & ~reset;
  assign w_accept    = bus.req_valid & w_req_ready;

  assign w_old_lane  = r_lane ? bus.arr_rdata[2*LANE_W-1:LANE_W]
                              : bus.arr_rdata[LANE_W-1:0];

  byte_merge u_byte_merge (
    .i_new_data (r_data),
    .i_old_data (w_old_lane),
    .i_mask     (r_mask),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_state_next = r_state;
    w_arr_en     = 1'b0;
    w_arr_wmode  = 1'b0;
    w_arr_addr   = '0;
    w_arr_wdata  = '0;
    w_arr_wmask  = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!bus.req_write) begin
            w_arr_en     = 1'b1;
            w_arr_addr   = w_req_row;
            w_state_next = ST_RD;
          end else if (w_mask_full) begin
            w_arr_en     = 1'b1;
            w_arr_wmode  = 1'b1;
            w_arr_addr   = w_req_row;
            w_arr_wdata  = {bus.req_data, bus.req_data};
            w_arr_wmask  = lane_onehot(w_req_lane);
            w_state_next = ST_RESP;
          end else if (w_mask_none) begin
            w_state_next = ST_RESP;
          end else begin
            // Partial write: fetch the old row first, merge next cycle
            w_arr_en     = 1'b1;
            w_arr_addr   = w_req_row;
            w_state_next = ST_RD;
          end
        end
      end
      ST_RD: begin
        w_state_next = ST_RESP;
        if (r_write) begin
          w_arr_en    = 1'b1;
          w_arr_wmode = 1'b1;
          w_arr_addr  = r_row;
          w_arr_wdata = {w_merged, w_merged};
          w_arr_wmask = lane_onehot(r_lane);
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Reset kills any array access in flight, including the RMW write phase
    if (reset) begin
      w_arr_en    = 1'b0;
      w_arr_wmode = 1'b0;
      w_arr_addr  = '0;
      w_arr_wdata = '0;
      w_arr_wmask = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lane       <= 1'b0;
      r_write      <= 1'b0;
      r_mask       <= '0;
      r_data       <= '0;
      r_row        <= '0;
      r_resp_write <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_lane  <= w_req_lane;
        r_write <= bus.req_write;
        r_mask  <= bus.req_mask;
        r_data  <= bus.req_data;
        r_row   <= w_req_row;
        if (bus.req_write && (w_mask_full || w_mask_none)) begin
          r_resp_write <= 1'b1;
          r_resp_data  <= '0;
        end
      end
      if (r_state == ST_RD) begin
        r_resp_write <= r_write;
        r_resp_data  <= r_write ? '0 : w_old_lane;
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_write = r_resp_write;
  assign bus.resp_data  = r_resp_data;

  assign bus.arr_en     = w_arr_en;
  assign bus.arr_wmode  = w_arr_wmode;
  assign bus.arr_addr   = w_arr_addr;
  assign bus.arr_wdata  = w_arr_wdata;
  assign bus.arr_wmask  = w_arr_wmask;

endmodule

`default_nettype wire
